glyph_rain_ctrl: RTL
====================

GLYPH_RAIN_CTRL -- requirements
Module: glyph_rain_ctrl

Interface
REQ-001 SHALL have parameter SPEED_DIV, default 4, meaning frame_tick pulses per lane-update sweep (legal 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port frame_tick, input, 1: one-cycle pulse at vblank start.
REQ-005 SHALL have port hpos, input, 10: pixel column, 0..639 when visible.
REQ-006 SHALL have port vpos, input, 10: pixel line, 0..479 when visible.
REQ-007 SHALL have port visible, input, 1: display-active qualifier.
REQ-008 SHALL have port rom_c, output, 6: glyph index to glyph ROM.
REQ-009 SHALL have port rom_y, output, 4: glyph row to glyph ROM.
REQ-010 SHALL have port rom_x, output, 3: glyph bit index to glyph ROM.
REQ-011 SHALL have port rom_pixel, input, 1: combinational glyph ROM result for current rom_c/y/x.
REQ-012 SHALL have port pixel_out, output, 1: glyph pixel, aligned 2 cycles after hpos/vpos.
REQ-013 SHALL have port bright, output, 2: intensity 0..3, aligned with pixel_out.
REQ-014 SHALL have port sweep_busy, output, 1: high while lane update sweep runs.

Function
REQ-015 SHALL partition screen into 8x12 cells: col = hpos[9:3] (0..79), row = vpos/12 (0..39), sub = vpos mod 12; lane = col[3:0] (16 lanes).
REQ-016 SHALL hold per lane a 6-bit head (0..51) and 6-bit seed.
REQ-017 Stage 1 (cycle t+1) SHALL register rom_c = (seed[lane] + row) mod 64, rom_y = sub, rom_x = 7 - hpos[2:0], plus lane intensity and visible.
REQ-018 Intensity: d = head - row; row > head or d >= 12 -> 0; d = 0 -> 3; d 1..4 -> 2; d 5..11 -> 1.
REQ-019 Stage 2 (cycle t+2) SHALL register bright = visible_d ? intensity_d : 0 and pixel_out = rom_pixel AND (bright != 0).
REQ-020 FSM states IDLE, SWEEP; frame divider counts frame_tick in IDLE; on reaching SPEED_DIV it clears and FSM enters SWEEP next cycle.
REQ-021 SWEEP SHALL take exactly 16 cycles, lane 0..15 in order, then return to IDLE; sweep_busy = 1 throughout, 0 otherwise.
REQ-022 Each SWEEP cycle SHALL step a 16-bit Fibonacci LFSR (taps 16,14,13,11); lane advances (head+1) only if lfsr[0] = 1 before the step.
REQ-023 Advancing lane with head = 51 SHALL set head = 0 and seed = lfsr[5:0].
REQ-024 frame_tick during SWEEP SHALL be ignored (divider unchanged).
REQ-025 LFSR SHALL hold in IDLE; rendering pipeline SHALL run every cycle regardless of FSM state.
REQ-026 rom_c values 48..63 are legal (ROM folds them).

Reset
REQ-027 rst SHALL force: FSM IDLE, divider 0, LFSR 16'hACE1, head[i] = 3*i, seed[i] = i, rom_c/rom_y/rom_x 0, pixel_out 0, bright 0, sweep_busy 0.
REQ-028 rst asserted mid-SWEEP SHALL abort the sweep; partially updated lanes revert to reset values.

Configuration
REQ-029 Macro GLYPH_RAIN_TRAIL_EN defined: graded intensity per REQ-018.
REQ-030 Macro GLYPH_RAIN_TRAIL_EN undefined: any d in 0..11 (row <= head) SHALL yield intensity 3, else 0; all else unchanged.

Verification
REQ-031 After reset, hpos=0, vpos=0, visible=1 -> cycle+1: rom_c=0, rom_y=0, rom_x=7; cycle+2: bright=3, pixel_out=rom_pixel.
REQ-032 hpos=8, vpos=47 (lane 1, head 3, row 3, sub 11) -> rom_c=4, rom_y=11, bright=3; vpos=48 (row 4) -> bright=0.
REQ-033 hpos=120 (lane 15, head 45), vpos=12*40-1 (row 39): d=6 -> bright=1 with macro, bright=3 without.
REQ-034 Four frame_tick pulses (SPEED_DIV=4) -> sweep_busy high exactly 16 cycles from cycle after 4th tick; extra tick during sweep does not shorten next interval.
REQ-035 visible=0 with any hpos/vpos -> bright=0, pixel_out=0 two cycles later.
REQ-036 Run sweeps until lane head passes 51 -> head reads 0 (bright=3 at row 0), rom_c at row 0 equals captured lfsr[5:0]; rst mid-sweep -> REQ-027 values next cycle.

Source files
------------

// File: rtl/glyph_rain_ctrl.sv
// Glyph rain renderer: 2-stage pixel pipeline plus a 16-lane head/seed sweep FSM.
// GLYPH_RAIN_TRAIL_EN selects graded trail intensity; undefined gives a flat trail.
// Latency: rom_c/y/x at t+1, pixel_out/bright at t+2. No backpressure; runs every cycle.
module glyph_rain_ctrl #(
  parameter int SPEED_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       visible,
  output logic [5:0] rom_c,
  output logic [3:0] rom_y,
  output logic [2:0] rom_x,
  input  logic       rom_pixel,
  output logic       pixel_out,
  output logic [1:0] bright,
  output logic       sweep_busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]  state;
  logic [3:0]  div;
  logic [3:0]  sidx;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [5:0]  head [16];
  logic [5:0]  seed [16];

  logic [6:0]  row;
  logic [9:0]  row_x12;
  logic [3:0]  sub;
  logic [3:0]  lane;
  logic [5:0]  head_l;
  logic [6:0]  d;
  logic [6:0]  c_sum;
  logic [1:0]  intensity;
  logic [1:0]  int_d;
  logic        vis_d;
  logic        unused_bits;

  assign row     = 7'(vpos / 10'd12);
  assign row_x12 = 10'(row) * 10'd12;
  assign sub     = 4'(vpos - row_x12);
  assign lane    = hpos[6:3];
  assign head_l  = head[lane];
  assign d       = {1'b0, head_l} - row;
  assign c_sum   = {1'b0, seed[lane]} + row;
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign sweep_busy  = (state == SWEEP);
  assign unused_bits = ^{hpos[9:7], c_sum[6]};

  // d is only meaningful when the head is at or below this row
  always_comb begin
    intensity = 2'd0;
    if (row <= {1'b0, head_l} && d < 7'd12) begin
`ifdef GLYPH_RAIN_TRAIL_EN
      if (d == 7'd0)
        intensity = 2'd3;
      else if (d <= 7'd4)
        intensity = 2'd2;
      else
        intensity = 2'd1;
`else
      intensity = 2'd3;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_c     <= 6'd0;
      rom_y     <= 4'd0;
      rom_x     <= 3'd0;
      int_d     <= 2'd0;
      vis_d     <= 1'b0;
      bright    <= 2'd0;
      pixel_out <= 1'b0;
    end else begin
      rom_c     <= c_sum[5:0];
      rom_y     <= sub;
      rom_x     <= 3'd7 - hpos[2:0];
      int_d     <= intensity;
      vis_d     <= visible;
      bright    <= vis_d ? int_d : 2'd0;
      pixel_out <= rom_pixel & vis_d & (int_d != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div   <= 4'd0;
      sidx  <= 4'd0;
      lfsr  <= 16'hACE1;
      for (int i = 0; i < 16; i++) begin
        head[i] <= 6'(3 * i);
        seed[i] <= 6'(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            if (div == 4'(SPEED_DIV - 1)) begin
              div   <= 4'd0;
              sidx  <= 4'd0;
              state <= SWEEP;
            end else begin
              div <= div + 4'd1;
            end
          end
        end
        default: begin
          if (lfsr[0]) begin
            if (head[sidx] == 6'd51) begin
              head[sidx] <= 6'd0;
              seed[sidx] <= lfsr[5:0];
            end else begin
              head[sidx] <= head[sidx] + 6'd1;
            end
          end
          lfsr <= {lfsr_fb, lfsr[15:1]};
          sidx <= sidx + 4'd1;
          if (sidx == 4'd15)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule
